dcpu_prefetch: RTL
==================

// Module: dcpu_prefetch
// PURPOSE
//  Instruction prefetch buffer between the dcpu bus master and system memory.
//  - Slave port faces the CPU. Master port faces memory. Both are single-outstanding, classic cyc/stb/ack.
//  - Streams sequential 16-bit words ahead of the CPU into a DEPTH-entry queue.
//  - Sequential fetches that hit the queue are acked with zero wait states.
//  - Every other access passes through to memory.
// PARAMETERS
//  DEPTH  4   queue entries (16-bit words); power of 2, >=2
//  AW     32  byte-address width
// PORTS
//  i_clk        in   1   clock, all state on rising edge
//  i_reset_n    in   1   reset, asynchronous, active-low
//  i_cpu_cyc    in   1   CPU bus cycle active
//  i_cpu_stb    in   2   CPU byte strobes ([1]=hi, [0]=lo)
//  i_cpu_we     in   1   CPU write
//  i_cpu_addr   in   AW  CPU byte address
//  i_cpu_dat    in   16  CPU write data
//  o_cpu_ack    out  1   CPU access complete this cycle
//  o_cpu_dat    out  16  CPU read data, valid with o_cpu_ack
//  o_mem_cyc    out  1   memory cycle active
//  o_mem_stb    out  2   memory byte strobes
//  o_mem_we     out  1   memory write
//  o_mem_addr   out  AW  memory byte address
//  o_mem_dat    out  16  memory write data
//  i_mem_ack    in   1   memory access complete
//  i_mem_dat    in   16  memory read data
// BEHAVIOUR
//  Reset (async, i_reset_n=0):
//   - o_cpu_ack, o_mem_cyc, o_mem_stb, o_mem_we are forced to 0 immediately. o_mem_addr and o_mem_dat go to 0.
//   - Queue is emptied (count=0). State goes to IDLE.
//   - Any in-flight memory cycle is abandoned.
//  Registers:
//   - q_addr: address of the queue head.
//   - f_addr: next address to prefetch.
//   - count: 0..DEPTH.
//   - Both addresses are always even. All address increments are +2 modulo 2^AW, so 'hFFFF_FFFE wraps to 0.
//  Request: a CPU request is present when i_cpu_cyc=1 and i_cpu_stb!=0.
//  Hit: read (we=0), stb=2'b11, count>0, i_cpu_addr==q_addr.
//   - o_cpu_ack=1 combinationally in the same cycle. o_cpu_dat = head entry.
//   - At the edge: pop the head, q_addr+=2.
//  Miss: any other request (read miss, byte read, odd address, or write).
//   - If a prefetch cycle is in flight, hold the CPU (ack=0) until i_mem_ack. That word is discarded.
//   - Flush the queue, then drive the CPU request onto the memory port unchanged (stb, we, addr, dat).
//   - o_cpu_ack = i_mem_ack and o_cpu_dat = i_mem_dat, both combinationally.
//   - After a full-word read miss (we=0, stb=2'b11): q_addr = f_addr = addr+2, go to PREFETCH.
//   - After a write or partial read: queue stays empty, go to IDLE (no prefetch until the next full-word read miss).
//  Prefetch: in PREFETCH, with no CPU miss pending and (count + inflight) < DEPTH:
//   - Issue a read: o_mem_cyc=1, stb=2'b11, we=0, addr=f_addr.
//   - Hold the cycle until i_mem_ack. On ack: push i_mem_dat, f_addr+=2.
//   - One outstanding cycle max. A new cycle may start the cycle after an ack.
//  Same-cycle hit pop and prefetch push: count unchanged, both pointers advance.
//  Pop and push on a full queue: not possible; the push is only issued when count<DEPTH.
//  States:
//   - IDLE: to PASS on a miss.
//   - PREFETCH: to WAIT on a miss with a cycle in flight; to PASS on a miss without one.
//   - WAIT: to PASS on i_mem_ack.
//   - PASS: to PREFETCH or IDLE on i_mem_ack, per the miss rules above.
//  If the CPU drops cyc during PASS before ack, the memory cycle drops too. The queue stays flushed and state goes to IDLE.
// STRUCTURE
//  - dcpu_pkg holds: state encodings (IDLE/PREFETCH/WAIT/PASS), STB_WORD=2'b11, and the address increment constant 2.
//  - Sub-module dcpu_pf_fifo: DEPTH x 16 synchronous FIFO.
//    - Inputs push, pop, flush (flush has priority over push/pop); outputs count and head data.
//    - Same async active-low reset.
//  - Top level: FSM, q_addr/f_addr, hit compare, port muxing.
// TESTING
//  1. After reset, CPU reads 'h0000 (mem ack 2 cycles later, dat 'h1111):
//     CPU acked with 'h1111. Then mem reads 'h0002,'h0004,'h0006,'h0008 and stops; count=4.
//  2. Next CPU read 'h0002: ack in the same cycle, no mem cycle, dat = word@2.
//     Then a prefetch of 'h000A is issued; count returns to 4.
//  3. CPU read 'h0100 while prefetch 'h000A is in flight: CPU waits for that ack, the word is discarded,
//     then mem read 'h0100. Afterwards prefetch starts at 'h0102.
//  4. CPU write 'h0004 with stb=2'b01, dat 'hAB: mem sees the same stb/we/addr/dat.
//     Queue is flushed. The next read 'h0006 misses (mem cycle observed).
//  5. CPU read 'hFFFF_FFFE (miss): the following prefetch address is 'h0000_0000.
//  6. i_reset_n pulled low mid mem cycle, asynchronously: o_mem_cyc=0 before the next edge.
//     After release, count=0 and the first CPU read misses.

Source files
------------

// File: rtl/dcpu_pkg.sv
// rtl/dcpu_pkg.sv - shared types and constants for the dcpu prefetch buffer
package dcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_WAIT     = 2'd2,
    ST_PASS     = 2'd3
  } pf_state_t;

  localparam logic [1:0] STB_WORD = 2'b11;
  localparam int         ADDR_INC = 2;

endpackage

// File: rtl/dcpu_pf_fifo.sv
// rtl/dcpu_pf_fifo.sv - DEPTH x 16 synchronous FIFO holding prefetched words
module dcpu_pf_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [15:0]   wr_dat,
  output logic [CW-1:0] count,
  output logic [15:0]   head
);

  localparam int PW = $clog2(DEPTH);

  logic [15:0]   store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = store[rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge i_clk) begin
    if (do_push && !flush) store[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/dcpu_prefetch.sv
// rtl/dcpu_prefetch.sv - sequential instruction prefetch buffer between dcpu and memory
module dcpu_prefetch
  import dcpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cpu_cyc,
  input  logic [1:0]    i_cpu_stb,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [15:0]   i_cpu_dat,
  output logic          o_cpu_ack,
  output logic [15:0]   o_cpu_dat,
  output logic          o_mem_cyc,
  output logic [1:0]    o_mem_stb,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [15:0]   o_mem_dat,
  input  logic          i_mem_ack,
  input  logic [15:0]   i_mem_dat
);

  localparam int CW = $clog2(DEPTH + 1);

  pf_state_t     state, state_nx;
  logic [AW-1:0] q_addr, f_addr, miss_next;
  logic [CW-1:0] count;
  logic [15:0]   head;
  logic          pf_cyc, pf_start;
  logic          req, full_rd, hit, miss;
  logic          push, pop, flush, load;

  assign req       = i_cpu_cyc && (i_cpu_stb != 2'b00);
  assign full_rd   = !i_cpu_we && (i_cpu_stb == STB_WORD);
  assign hit       = (state == ST_PREFETCH) && req && full_rd && (count != '0) && (i_cpu_addr == q_addr);
  assign miss      = req && !hit;
  assign miss_next = {i_cpu_addr[AW-1:1], 1'b0} + AW'(ADDR_INC);

  dcpu_pf_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wr_dat    (i_mem_dat),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    state_nx   = state;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    load       = 1'b0;
    pf_start   = 1'b0;
    o_cpu_ack  = 1'b0;
    o_cpu_dat  = '0;
    o_mem_cyc  = 1'b0;
    o_mem_stb  = '0;
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_dat  = '0;
    // A live prefetch cycle owns the memory port until its ack.
    if (pf_cyc && (state == ST_PREFETCH || state == ST_WAIT)) begin
      o_mem_cyc  = 1'b1;
      o_mem_stb  = STB_WORD;
      o_mem_addr = f_addr;
    end
    case (state)
      ST_IDLE: begin
        if (miss) state_nx = ST_PASS;
      end
      ST_PREFETCH: begin
        if (hit) begin
          pop       = 1'b1;
          o_cpu_ack = 1'b1;
          o_cpu_dat = head;
        end
        if (miss) begin
          flush    = 1'b1;
          state_nx = (pf_cyc && !i_mem_ack) ? ST_WAIT : ST_PASS;
        end else begin
          push     = pf_cyc && i_mem_ack;
          pf_start = !pf_cyc && (count < CW'(DEPTH));
        end
      end
      ST_WAIT: begin
        if (i_mem_ack) state_nx = ST_PASS;
      end
      ST_PASS: begin
        o_mem_cyc  = req;
        o_mem_stb  = i_cpu_stb;
        o_mem_we   = i_cpu_we;
        o_mem_addr = i_cpu_addr;
        o_mem_dat  = i_cpu_dat;
        o_cpu_ack  = req && i_mem_ack;
        o_cpu_dat  = i_mem_dat;
        if (!req) begin
          state_nx = ST_IDLE;
        end else if (i_mem_ack) begin
          load     = full_rd;
          state_nx = full_rd ? ST_PREFETCH : ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      q_addr <= '0;
      f_addr <= '0;
      pf_cyc <= 1'b0;
    end else begin
      state <= state_nx;
      if (pf_start)
        pf_cyc <= 1'b1;
      else if (pf_cyc && i_mem_ack)
        pf_cyc <= 1'b0;
      if (load) begin
        q_addr <= miss_next;
        f_addr <= miss_next;
      end else begin
        if (pop)  q_addr <= q_addr + AW'(ADDR_INC);
        if (push) f_addr <= f_addr + AW'(ADDR_INC);
      end
    end
  end

endmodule
